// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: column-scanning matrix keypad controller.
// Drives one column low at a time, samples the synchronised rows, debounces press and
// release, maps the key position to a code and queues codes in a first-word-fall-through
// FIFO with a valid/ready consumer handshake.
module keypad_scan_ctrl #(
  parameter int unsigned ROWS         = 4,
  parameter int unsigned COLS         = 4,
  parameter int unsigned SETTLE_CYC   = 1000,
  parameter int unsigned DEBOUNCE_CYC = 50000,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned LEGEND_EN    = 1,
  localparam int unsigned IDX_W = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1,
  localparam int unsigned KEY_W = ((LEGEND_EN != 0) && (IDX_W < 4)) ? 4 : IDX_W,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ROWS-1:0]  row_n,
  output logic [COLS-1:0]  col_n,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  input  logic             key_ready,
  output logic             key_down,
  output logic [CNT_W-1:0] fifo_count,
  output logic             overflow
);

  localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned COL_W = $clog2(COLS);
  localparam int unsigned SET_W = $clog2(SETTLE_CYC);
  localparam int unsigned DEB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_RELEASE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [ROWS-1:0]  rs_meta_q, rs_q;
  logic [COL_W-1:0] col_q, col_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic [DEB_W-1:0] stable_q, stable_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [ROWS-1:0]  pat_q, pat_d;
  logic             key_down_q, key_down_d;
  logic             overflow_q;

  logic [KEY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  logic             any_low_c, match_c, settle_done_c, stable_done_c;
  logic [ROW_W-1:0] low_row_c;
  logic [COL_W-1:0] col_next_c;
  logic             push_c, pop_c, full_c, push_ok_c, drop_c;
  logic [IDX_W-1:0] idx_c;
  logic [KEY_W-1:0] key_c;

  // 4x4 legend: position index to printed key value
  function automatic logic [KEY_W-1:0] legend_code(input logic [IDX_W-1:0] idx);
    logic [3:0] code;
    case (4'(idx))
      4'd0:    code = 4'h1;
      4'd1:    code = 4'h2;
      4'd2:    code = 4'h3;
      4'd3:    code = 4'hA;
      4'd4:    code = 4'h4;
      4'd5:    code = 4'h5;
      4'd6:    code = 4'h6;
      4'd7:    code = 4'hB;
      4'd8:    code = 4'h7;
      4'd9:    code = 4'h8;
      4'd10:   code = 4'h9;
      4'd11:   code = 4'hC;
      4'd12:   code = 4'hF;
      4'd13:   code = 4'h0;
      4'd14:   code = 4'hE;
      default: code = 4'hD;
    endcase
    return KEY_W'(code);
  endfunction

  // Two-flop synchroniser for the asynchronous row inputs; idle rows read high
  always_ff @(posedge clk) begin
    if (rst) begin
      rs_meta_q <= '1;
      rs_q      <= '1;
    end else begin
      rs_meta_q <= row_n;
      rs_q      <= rs_meta_q;
    end
  end

  // Lowest-index row currently pulled low
  always_comb begin
    low_row_c = '0;
    for (int r = int'(ROWS) - 1; r >= 0; r--) begin
      if (!rs_q[r]) low_row_c = ROW_W'(r);
    end
  end

  // Shared scan/debounce status decodes
  always_comb begin
    any_low_c     = ~&rs_q;
    match_c       = (rs_q == pat_q);
    settle_done_c = (settle_q == SET_W'(SETTLE_CYC - 1));
    stable_done_c = (stable_q == DEB_W'(DEBOUNCE_CYC - 1));
    col_next_c    = (col_q == COL_W'(COLS - 1)) ? '0 : col_q + COL_W'(1);
  end

  // FSM state register together with its scan/debounce counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_SCAN;
      col_q      <= '0;
      settle_q   <= '0;
      stable_q   <= '0;
      row_q      <= '0;
      pat_q      <= '1;
      key_down_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      settle_q   <= settle_d;
      stable_q   <= stable_d;
      row_q      <= row_d;
      pat_q      <= pat_d;
      key_down_q <= key_down_d;
    end
  end

  // Next-state: settle, debounce-press and debounce-release sequencing
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    settle_d = settle_q;
    stable_d = stable_q;
    row_d    = row_q;
    pat_d    = pat_q;
    unique case (state_q)
      ST_SCAN: begin
        if (settle_done_c) begin
          settle_d = '0;
          if (any_low_c) begin
            state_d  = ST_DEBOUNCE;
            row_d    = low_row_c;
            pat_d    = rs_q;
            stable_d = '0;
          end else begin
            col_d = col_next_c;
          end
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end
      ST_DEBOUNCE: begin
        if (!match_c) begin
          state_d  = ST_SCAN;
          col_d    = col_next_c;
          settle_d = '0;
          stable_d = '0;
        end else if (stable_done_c) begin
          state_d  = ST_RELEASE;
          stable_d = '0;
        end else begin
          stable_d = stable_q + DEB_W'(1);
        end
      end
      ST_RELEASE: begin
        if (any_low_c) begin
          stable_d = '0;
        end else if (stable_done_c) begin
          state_d  = ST_SCAN;
          col_d    = col_next_c;
          settle_d = '0;
          stable_d = '0;
        end else begin
          stable_d = stable_q + DEB_W'(1);
        end
      end
      default: state_d = ST_SCAN;
    endcase
  end

  // FSM outputs: column drive, push request and held-key level
  always_comb begin
    push_c     = 1'b0;
    key_down_d = key_down_q;
    col_n      = rst ? '1 : ~(COLS'(1) << col_q);
    case (state_q)
      ST_DEBOUNCE: begin
        if (match_c && stable_done_c) begin
          push_c     = 1'b1;
          key_down_d = 1'b1;
        end
      end
      ST_RELEASE: begin
        if (!any_low_c && stable_done_c) key_down_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Key code of the latched row and current column
  always_comb begin
    idx_c = IDX_W'(row_q) * IDX_W'(COLS) + IDX_W'(col_q);
    key_c = (LEGEND_EN != 0) ? legend_code(idx_c) : KEY_W'(idx_c);
  end

  // FIFO handshake: a pop frees the slot so a push into a full FIFO still lands
  always_comb begin
    pop_c     = key_valid & key_ready;
    full_c    = (count_q == CNT_W'(DEPTH));
    push_ok_c = push_c & (~full_c | pop_c);
    drop_c    = push_c & full_c & ~pop_c;
  end

  // FIFO pointers, occupancy and overflow pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_c)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q    <= count_q + CNT_W'(push_ok_c) - CNT_W'(pop_c);
      overflow_q <= drop_c;
    end
  end

  // FIFO storage; contents are only observed while occupancy is non-zero
  always_ff @(posedge clk) begin
    if (push_ok_c) mem_q[wr_ptr_q] <= key_c;
  end

  assign key_code   = mem_q[rd_ptr_q];
  assign key_valid  = (count_q != '0);
  assign key_down   = key_down_q;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Testbench for keypad_scan_ctrl: keypad matrix model drives the rows, expected codes
// are derived from the legend table and kept in a queue-based FIFO reference.
`timescale 1ns/1ps
module tb_keypad_scan_ctrl;

  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready = 1'b0;
  logic       key_down;
  logic [2:0] fifo_count;
  logic       overflow;

  logic [15:0] keys = '0;
  int total = 0;
  int bad = 0;
  int ovf_seen = 0;
  int ovf_exp = 0;
  logic [3:0] exp_q[$];
  logic [3:0] leg_tbl [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                               4'h7, 4'h8, 4'h9, 4'hC, 4'hF, 4'h0, 4'hE, 4'hD};

  always #5 clk = ~clk;

  keypad_scan_ctrl #(
    .ROWS(4), .COLS(4), .SETTLE_CYC(4), .DEBOUNCE_CYC(8), .DEPTH(DEPTH), .LEGEND_EN(1)
  ) dut (
    .clk(clk), .rst(rst), .row_n(row_n), .col_n(col_n), .key_code(key_code),
    .key_valid(key_valid), .key_ready(key_ready), .key_down(key_down),
    .fifo_count(fifo_count), .overflow(overflow)
  );

  // Keypad matrix: a pressed key pulls its row low while its column is driven low
  always_comb begin
    row_n = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  always @(negedge clk) if (overflow === 1'b1) ovf_seen++;

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic press_release(input logic [15:0] mask, input logic [3:0] code, input string tag);
    int n;
    keys = mask;
    n = 0;
    while (key_down !== 1'b1 && n < 30) begin tick(); n++; end
    chk({tag, "_down"}, 32'(key_down === 1'b1), 1);
    if (exp_q.size() < DEPTH) exp_q.push_back(code);
    else ovf_exp++;
    keys = '0;
    n = 0;
    while (key_down !== 1'b0 && n < 16) begin tick(); n++; end
    chk({tag, "_up"}, 32'(key_down === 1'b0), 1);
  endtask

  task automatic pop_chk(input string tag);
    chk({tag, "_valid"}, 32'(key_valid), 1);
    chk({tag, "_code"}, 32'(key_code), 32'(exp_q[0]));
    key_ready = 1'b1;
    tick();
    key_ready = 1'b0;
    void'(exp_q.pop_front());
  endtask

  initial begin
    logic [3:0]  one;
    logic [3:0]  exp_col;
    logic [3:0]  prev;
    logic [15:0] m;
    int n, run, aborted, idx, npop;
    one = 4'b0001;

    // 1: reset state and idle scan rotation
    rst = 1'b1;
    repeat (3) tick();
    chk("t1_rst_col", 32'(col_n), 32'hF);
    chk("t1_rst_outs", 32'({key_valid, key_down, overflow, fifo_count}), 0);
    rst = 1'b0;
    #1;
    for (int k = 0; k <= 16; k++) begin
      exp_col = ~(one << ((k / 4) % 4));
      chk("t1_col", 32'(col_n), 32'(exp_col));
      chk("t1_outs", 32'({key_valid, key_down, overflow, fifo_count}), 0);
      tick();
    end

    // 2: hold idx 6, latency bound, release hold-off, consumer pop
    keys[6] = 1'b1;
    n = 0;
    while (key_valid !== 1'b1 && n < 27) begin tick(); n++; end
    chk("t2_latency", 32'(key_valid), 1);
    chk("t2_code", 32'(key_code), 32'h6);
    chk("t2_down", 32'(key_down), 1);
    chk("t2_cnt", 32'(fifo_count), 1);
    keys[6] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("t2_hold", 32'(key_down), 1);
    end
    n = 0;
    while (key_down !== 1'b0 && n < 8) begin tick(); n++; end
    chk("t2_up", 32'(key_down), 0);
    key_ready = 1'b1;
    tick();
    key_ready = 1'b0;
    chk("t2_pop_valid", 32'(key_valid), 0);
    chk("t2_pop_cnt", 32'(fifo_count), 0);

    // 3: ordering, then two keys in one column give one code from the lower row
    press_release(16'(1) << 12, leg_tbl[12], "t3a");
    press_release(16'(1) << 13, leg_tbl[13], "t3b");
    chk("t3_cnt", 32'(fifo_count), 2);
    pop_chk("t3_pop_f");
    pop_chk("t3_pop_0");
    m = '0;
    m[3] = 1'b1;
    m[11] = 1'b1;
    press_release(m, 4'hA, "t3c");
    chk("t3c_cnt", 32'(fifo_count), 1);
    pop_chk("t3c_pop");

    // 4: bouncing key never debounces; an aborted debounce moves to the next column
    aborted = 0;
    prev = col_n;
    run = 1;
    for (int i = 0; i < 96; i++) begin
      if (i % 3 == 0) keys[5] = ~keys[5];
      tick();
      if (col_n !== prev) begin
        chk("t4_next_col", 32'(col_n), 32'({prev[2:0], prev[3]}));
        if (run > 4) aborted++;
        prev = col_n;
        run = 1;
      end else begin
        run++;
      end
    end
    keys = '0;
    repeat (10) tick();
    chk("t4_aborted", 32'(aborted > 0), 1);
    chk("t4_nopush", 32'({key_valid, key_down, fifo_count}), 0);

    // 5: fill, overflow on the fifth press, push+pop while full
    for (int k = 0; k < 5; k++) press_release(16'(1) << k, leg_tbl[k], "t5_press");
    chk("t5_cnt", 32'(fifo_count), 4);
    chk("t5_ovf", 32'(ovf_seen), 32'(ovf_exp));
    n = 0;
    while (col_n !== 4'b0111 && n < 20) begin tick(); n++; end
    chk("t5_find_c3", 32'(col_n), 32'h7);
    keys[5] = 1'b1;
    n = 0;
    while (col_n !== 4'b1101 && n < 20) begin tick(); n++; end
    chk("t5_find_c1", 32'(col_n), 32'hD);
    repeat (11) tick();
    chk("t5_pp_head", 32'(key_code), 32'(exp_q[0]));
    key_ready = 1'b1;
    tick();
    key_ready = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(leg_tbl[5]);
    chk("t5_pp_down", 32'(key_down), 1);
    chk("t5_pp_cnt", 32'(fifo_count), 4);
    keys[5] = 1'b0;
    n = 0;
    while (key_down !== 1'b0 && n < 16) begin tick(); n++; end
    chk("t5_pp_up", 32'(key_down), 0);
    chk("t5_pp_ovf", 32'(ovf_seen), 32'(ovf_exp));
    while (exp_q.size() > 0) pop_chk("t5_pop");
    chk("t5_empty", 32'(fifo_count), 0);

    // 6a: reset in the middle of a debounce
    keys[6] = 1'b1;
    run = 0;
    n = 0;
    while (run < 6 && n < 64) begin
      tick();
      n++;
      if (col_n === 4'b1011) run++;
      else run = 0;
    end
    chk("t6_in_deb", 32'(run), 6);
    rst = 1'b1;
    tick();
    chk("t6a_outs", 32'({key_valid, key_down, fifo_count}), 0);
    chk("t6a_col", 32'(col_n), 32'hF);
    keys = '0;
    tick();
    rst = 1'b0;
    #1;
    chk("t6a_col0", 32'(col_n), 32'hE);
    repeat (4) tick();
    chk("t6a_col1", 32'(col_n), 32'hD);
    repeat (30) tick();
    chk("t6a_nopush", 32'(key_valid), 0);

    // 6b: reset with two entries queued
    press_release(16'(1) << 7, leg_tbl[7], "t6b_p0");
    press_release(16'(1) << 8, leg_tbl[8], "t6b_p1");
    chk("t6b_cnt", 32'(fifo_count), 2);
    rst = 1'b1;
    tick();
    exp_q.delete();
    chk("t6b_outs", 32'({key_valid, key_down, fifo_count}), 0);
    chk("t6b_col", 32'(col_n), 32'hF);
    rst = 1'b0;
    #1;
    chk("t6b_col0", 32'(col_n), 32'hE);

    // Randomised presses and pops against the queue reference
    for (int it = 0; it < 10; it++) begin
      idx = int'($urandom_range(0, 15));
      m = '0;
      m[idx] = 1'b1;
      press_release(m, leg_tbl[idx], $sformatf("rnd%0d", it));
      chk("rnd_cnt", 32'(fifo_count), 32'(exp_q.size()));
      chk("rnd_ovf", 32'(ovf_seen), 32'(ovf_exp));
      npop = int'($urandom_range(0, exp_q.size()));
      repeat (npop) pop_chk("rnd_pop");
    end
    while (exp_q.size() > 0) pop_chk("drain");
    chk("drain_cnt", 32'(fifo_count), 0);
    chk("final_ovf", 32'(ovf_seen), 32'(ovf_exp));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
